// File: rtl/arm_ctrl_pkg.sv
// Shared alarm definitions: FSM state encodings and default arming delay,
// common to the arming controller, disarm sequencer and supervisor.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_OPEN  = 3'd1,
    ST_WAIT_CLOSE = 3'd2,
    ST_COUNT      = 3'd3,
    ST_ARMED      = 3'd4
  } arm_state_e;

  localparam int T_ARM_DELAY_DEF = 6;
  localparam int CW_DEF          = 4;

endpackage

// File: rtl/arm_ctrl_timer.sv
// Loadable arming down-counter: counts 1 Hz ticks while enabled, never wraps,
// and flags done on the tick that would take it from 1 to 0.
module arm_ctrl_timer
  import arm_ctrl_pkg::*;
#(
  parameter int T_ARM_DELAY = T_ARM_DELAY_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          clr,
  input  logic          cnt_en,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(T_ARM_DELAY);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_d, cnt_q;

  assign done = cnt_en & tick & (cnt_q == ONE);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (load)           cnt_d = LOAD_VAL;
    else if (cnt_en && tick) cnt_d = (cnt_q > ONE) ? cnt_q - ONE : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/arm_ctrl.sv
// Car alarm arming controller: ignition off -> driver door open -> all doors
// closed -> tick-driven countdown -> armed, with a one-cycle arm pulse.
module arm_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int T_ARM_DELAY = T_ARM_DELAY_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          ignition,
  input  logic          d_door,
  input  logic          p_door,
  input  logic          tick,
  output logic          arming,
  output logic          armed,
  output logic          arm_pulse,
  output logic [CW-1:0] time_left
);

  arm_state_e state_d, state_q;
  logic       arm_pulse_d, arm_pulse_q;
  logic       load, clr, cnt_en, done;

  always_comb begin
    state_d     = state_q;
    arm_pulse_d = 1'b0;
    load        = 1'b0;
    if (!en || ignition) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_OPEN;
        ST_WAIT_OPEN:  if (d_door) state_d = ST_WAIT_CLOSE;
        ST_WAIT_CLOSE: if (!d_door && !p_door) begin
                         state_d = ST_COUNT;
                         load    = 1'b1;
                       end
        // A door event beats a completing tick in the same cycle
        ST_COUNT:      if (d_door || p_door) state_d = ST_WAIT_CLOSE;
                       else if (done) begin
                         state_d     = ST_ARMED;
                         arm_pulse_d = 1'b1;
                       end
        ST_ARMED:      state_d = ST_ARMED;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  assign cnt_en = (state_q == ST_COUNT);
  assign clr    = (state_d != ST_COUNT);

  arm_ctrl_timer #(.T_ARM_DELAY(T_ARM_DELAY), .CW(CW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .clr    (clr),
    .cnt_en (cnt_en),
    .tick   (tick),
    .cnt    (time_left),
    .done   (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      arm_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_pulse_q <= arm_pulse_d;
    end
  end

  assign arming    = (state_q == ST_COUNT);
  assign armed     = (state_q == ST_ARMED);
  assign arm_pulse = arm_pulse_q;

endmodule

// File: tb/tb_arm_ctrl.sv
// Bench for arm_ctrl: directed scenarios with literal expectations plus a
// randomized run, all cross-checked against a behavioural arming model.
module tb_arm_ctrl;

  localparam int T  = 3;
  localparam int CW = 4;

  // stimulus bits {reset, en, ignition, d_door, p_door, tick}
  localparam logic [5:0] R  = 6'b100000;
  localparam logic [5:0] E  = 6'b010000;
  localparam logic [5:0] IG = 6'b001000;
  localparam logic [5:0] D  = 6'b000100;
  localparam logic [5:0] P  = 6'b000010;
  localparam logic [5:0] TK = 6'b000001;

  // expected {arming, armed, arm_pulse, time_left}
  localparam logic [6:0] Z  = 7'b000_0000;
  localparam logic [6:0] C3 = 7'b100_0011;
  localparam logic [6:0] C2 = 7'b100_0010;
  localparam logic [6:0] C1 = 7'b100_0001;
  localparam logic [6:0] AP = 7'b011_0000;
  localparam logic [6:0] AH = 7'b010_0000;

  logic clock = 1'b0;
  logic reset, en, ignition, d_door, p_door, tick;
  logic arming, armed, arm_pulse;
  logic [CW-1:0] time_left;

  int vectors = 0, miscompares = 0;

  // Model: has the block been live a cycle, has the driver door been seen
  // open, seconds still to count (counting flag), armed, pulse this cycle.
  bit m_live, m_opened, m_counting, m_armed, m_pulse;
  int m_left;

  always #5 clock = ~clock;

  arm_ctrl #(.T_ARM_DELAY(T), .CW(CW)) dut (
    .clock(clock), .reset(reset), .en(en), .ignition(ignition),
    .d_door(d_door), .p_door(p_door), .tick(tick),
    .arming(arming), .armed(armed), .arm_pulse(arm_pulse), .time_left(time_left)
  );

  task automatic model_step(input logic [5:0] v);
    bit r, e, ig, d, p, t;
    {r, e, ig, d, p, t} = v;
    m_pulse = 0;
    if (r || !e || ig) begin
      m_live = 0; m_opened = 0; m_counting = 0; m_armed = 0; m_left = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (m_armed) begin
      m_armed = 1;
    end else if (m_counting) begin
      if (d || p) begin
        m_counting = 0; m_left = 0;
      end else if (t) begin
        if (m_left == 1) begin
          m_counting = 0; m_left = 0; m_armed = 1; m_pulse = 1;
        end else m_left = m_left - 1;
      end
    end else if (m_opened) begin
      if (!d && !p) begin m_counting = 1; m_left = T; end
    end else if (d) begin
      m_opened = 1;
    end
  endtask

  task automatic cyc(input logic [5:0] v);
    {reset, en, ignition, d_door, p_door, tick} = v;
    @(posedge clock);
    model_step(v);
    #1;
  endtask

  function automatic logic [6:0] dut_v();
    return {arming, armed, arm_pulse, time_left};
  endfunction

  function automatic logic [6:0] mdl_v();
    return {m_counting, m_armed, m_pulse, CW'(m_left)};
  endfunction

  task automatic test_reset();
    cyc(R | E | D | TK);
    vectors++;
    if (dut_v() !== Z) begin
      miscompares++; $display("FAIL reset_state: got %b expected %b", dut_v(), Z);
    end
    vectors++;
    if (dut_v() !== mdl_v()) begin
      miscompares++; $display("FAIL reset_model: got %b model %b", dut_v(), mdl_v());
    end
  endtask

  task automatic test_basic_arm();
    logic [5:0] s[$] = '{R|E, E, E|D, E, E|TK, E|TK, E|TK, E, E};
    logic [6:0] x[$] = '{Z,   Z, Z,   C3, C2,  C1,   AP,   AH, AH};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== x[i]) begin
        miscompares++; $display("FAIL basic_arm step%0d: got %b expected %b", i, dut_v(), x[i]);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++; $display("FAIL basic_arm_model step%0d: got %b model %b", i, dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_door_abort();
    logic [5:0] s[$] = '{R|E, E, E|D, E, E|TK, E|P, E|P, E, E|TK, E|TK, E|TK};
    logic [6:0] x[$] = '{Z,   Z, Z,   C3, C2,  Z,   Z,   C3, C2,  C1,   AP};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== x[i]) begin
        miscompares++; $display("FAIL door_abort step%0d: got %b expected %b", i, dut_v(), x[i]);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++; $display("FAIL door_abort_model step%0d: got %b model %b", i, dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_pdoor_ignored();
    logic [5:0] s[$] = '{R|E, E, E|P, E, E|P, E|TK, E|P|TK, E};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== Z) begin
        miscompares++; $display("FAIL pdoor_ignored step%0d: got %b expected %b", i, dut_v(), Z);
      end
    end
    // idle with no door activity, then prove it was still waiting for the open
    for (int i = 0; i < 20; i++) cyc(E | ((i % 3 == 0) ? TK : 6'b0));
    vectors++;
    if (dut_v() !== Z) begin
      miscompares++; $display("FAIL wait_open_idle: got %b expected %b", dut_v(), Z);
    end
    cyc(E | D);
    cyc(E);
    vectors++;
    if (dut_v() !== C3) begin
      miscompares++; $display("FAIL wait_open_then_arm: got %b expected %b", dut_v(), C3);
    end
  endtask

  task automatic test_armed_hold();
    logic [5:0] s[$] = '{R|E, E, E|D, E, E|TK, E|TK, E|TK, E|D, E|D|P, E|TK, E|IG,
                         E, E|D, E, E|TK, E|TK, E|TK, E|P};
    logic [6:0] x[$] = '{Z,   Z, Z,   C3, C2,  C1,   AP,   AH,  AH,    AH,   Z,
                         Z, Z,   C3, C2,  C1,   AP,   AH};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== x[i]) begin
        miscompares++; $display("FAIL armed_hold step%0d: got %b expected %b", i, dut_v(), x[i]);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++; $display("FAIL armed_hold_model step%0d: got %b model %b", i, dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_door_tick_same_cycle();
    logic [5:0] s[$] = '{R|E, E, E|D, E, E|TK, E|TK, E|D|TK, E|D, E};
    logic [6:0] x[$] = '{Z,   Z, Z,   C3, C2,  C1,   Z,      Z,   C3};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== x[i]) begin
        miscompares++; $display("FAIL door_tick_same step%0d: got %b expected %b", i, dut_v(), x[i]);
      end
    end
  endtask

  task automatic test_abort_mid_count();
    logic [5:0] s[$] = '{R|E, E, E|D, E, E|TK, R|E|TK, E, E|TK, E, E|D, E,
                         E|TK, TK, 6'b0, E, E, E|D, E};
    logic [6:0] x[$] = '{Z,   Z, Z,   C3, C2,  Z,      Z, Z,    Z, Z,   C3,
                         C2,  Z,  Z,     Z, Z, Z,   C3};
    foreach (s[i]) begin
      cyc(s[i]);
      vectors++;
      if (dut_v() !== x[i]) begin
        miscompares++; $display("FAIL abort_mid step%0d: got %b expected %b", i, dut_v(), x[i]);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++; $display("FAIL abort_mid_model step%0d: got %b model %b", i, dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] v;
    int armed_seen = 0;
    cyc(R | E);
    for (int i = 0; i < 600; i++) begin
      v = {($urandom % 80) == 0, ($urandom % 30) != 0, ($urandom % 40) == 0,
           ($urandom % 10) == 0, ($urandom % 14) == 0, ($urandom % 2) == 0};
      cyc(v);
      if (m_pulse) armed_seen++;
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL random cyc%0d in=%b: got %b model %b", i, v, dut_v(), mdl_v());
      end
    end
    $display("random run: %0d arm events", armed_seen);
  endtask

  initial begin
    {reset, en, ignition, d_door, p_door, tick} = '0;
    test_reset();
    test_basic_arm();
    test_door_abort();
    test_pdoor_ignored();
    test_armed_hold();
    test_door_tick_same_cycle();
    test_abort_mid_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
